cam_capture_scaled: RTL and testbench

CAM_CAPTURE_SCALED -- requirements
Module: cam_capture_scaled

---
 rtl/cam_capture_scaled.sv | 249 ++++++++++++++++++++++++
 tb/tb_cam_capture_scaled.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_scaled.sv
// cam_capture_scaled
// Captures an 8-bit parallel camera stream (OV7670 style: pclk/href/vsync/data)
// into a frame buffer write port, decimating by G_DECIM in both directions.
//
// The camera signals are asynchronous to clk. They are brought in through a
// three-flop chain, and all decisions are taken on the last stage.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pclk       camera byte clock (sampled, never used as a clock)
//   href       camera line valid
//   vsync      camera frame sync
//   data       camera byte bus
//   mode       00 RGB444, 01 RGB565, 1x YUV422 gray (Y byte only)
//   swap_r_b   exchange red and blue channels
//   enable     capture enable; sampled only at frame start
//   addr       buffer write address (row_base + out_col)
//   dout       buffer write data {R,G,B}, or Y in the top 8 bits in gray mode
//   we         one-clk buffer write strobe
//   frame_done one-clk pulse at the start of the frame that follows a frame
//              that wrote at least one pixel
//   line_err   one-clk pulse when a kept line did not deliver G_IMG_COLS pixels
//
// Optional feature (macro CAM_CAPTURE_STATS_EN):
//   frame_cnt  wrapping count of frame_done pulses
//   err_cnt    count of line_err pulses, saturating at 255
module cam_capture_scaled #(
  parameter int G_IMG_COLS = 80,
  parameter int G_IMG_ROWS = 60,
  parameter int G_NB_ADDR  = 13,
  parameter int G_NB_COLOR = 4,
  parameter int G_DECIM    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pclk,
  input  logic                      href,
  input  logic                      vsync,
  input  logic [7:0]                data,
  input  logic [1:0]                mode,
  input  logic                      swap_r_b,
  input  logic                      enable,
  output logic [G_NB_ADDR-1:0]      addr,
  output logic [3*G_NB_COLOR-1:0]   dout,
  output logic                      we,
  output logic                      frame_done,
  output logic                      line_err
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0]               frame_cnt,
  output logic [7:0]                err_cnt
`endif
);

  localparam int          PADW      = 3*G_NB_COLOR - 8;
  localparam logic [11:0] COLS_W    = 12'(G_IMG_COLS);
  localparam logic [11:0] ROWS_W    = 12'(G_IMG_ROWS);
  localparam logic [11:0] DMASK     = 12'(G_DECIM - 1);  // G_DECIM is a power of two
  localparam logic [15:0] COLS_STEP = 16'(G_IMG_COLS);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, WAIT_LINE, CAPTURE, LINE_END} state_t;
  state_t state_reg, state_next;

  // Input synchronisers: bit 2 is the stage every decision is based on.
  logic [2:0] pclk_sync_reg, href_sync_reg, vsync_sync_reg;
  logic [7:0] data_s1_reg, data_s2_reg, data_s3_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_sync_reg  <= '0;
      href_sync_reg  <= '0;
      vsync_sync_reg <= '0;
      data_s1_reg    <= '0;
      data_s2_reg    <= '0;
      data_s3_reg    <= '0;
    end else begin
      pclk_sync_reg  <= {pclk_sync_reg[1:0], pclk};
      href_sync_reg  <= {href_sync_reg[1:0], href};
      vsync_sync_reg <= {vsync_sync_reg[1:0], vsync};
      data_s1_reg    <= data;
      data_s2_reg    <= data_s1_reg;
      data_s3_reg    <= data_s2_reg;
    end
  end

  logic pclk_rise, href_s, vsync_s;
  assign pclk_rise = pclk_sync_reg[1] & ~pclk_sync_reg[2];
  assign href_s    = href_sync_reg[2];
  assign vsync_s   = vsync_sync_reg[2];

  // vsync qualifier: frame start fires once, on the 4th consecutive high sample.
  logic [2:0] vs_cnt_reg;
  logic       frame_start;
  assign frame_start = vsync_s && (vs_cnt_reg == 3'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                vs_cnt_reg <= '0;
    else if (!vsync_s)         vs_cnt_reg <= '0;
    else if (vs_cnt_reg != 3'd4) vs_cnt_reg <= vs_cnt_reg + 3'd1;
  end

  logic in_frame;
  assign in_frame = (state_reg == WAIT_LINE) || (state_reg == CAPTURE) || (state_reg == LINE_END);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (enable) state_next = WAIT_FRAME;
      WAIT_FRAME: if (frame_start) state_next = enable ? WAIT_LINE : IDLE;
      WAIT_LINE:  if (href_s) state_next = CAPTURE;
      CAPTURE:    if (!href_s) state_next = LINE_END;
      LINE_END:   state_next = WAIT_LINE;
      default:    state_next = IDLE;
    endcase
    // A new frame always wins; enable is only looked at here.
    if (in_frame && frame_start) state_next = enable ? WAIT_LINE : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Datapath
  logic                    toggle_reg, wrote_any_reg;
  logic [7:0]              byte0_reg;
  logic [11:0]             in_col_reg, out_col_reg, in_row_reg, out_row_reg;
  logic [15:0]             row_base_reg;
  logic [G_NB_ADDR-1:0]    addr_reg;
  logic [3*G_NB_COLOR-1:0] dout_reg, dout_next;
  logic                    we_reg, frame_done_reg, line_err_reg;

  logic byte_go, col_kept, row_kept, in_bounds;
  assign byte_go   = pclk_rise && href_s && ((state_reg == WAIT_LINE) || (state_reg == CAPTURE));
  assign col_kept  = (in_col_reg & DMASK) == 12'd0;
  assign row_kept  = (in_row_reg & DMASK) == 12'd0;
  assign in_bounds = (out_col_reg < COLS_W) && (out_row_reg < ROWS_W);

  // Pixel assembly from byte0 (held) and byte1 (current sample).
  logic [15:0]             pix_word;
  logic [G_NB_COLOR-1:0]   pix_r, pix_g, pix_b;
  assign pix_word = {byte0_reg, data_s3_reg};

  always_comb begin
    if (mode[0]) begin
      pix_r = pix_word[15 -: G_NB_COLOR];
      pix_g = pix_word[10 -: G_NB_COLOR];
      pix_b = pix_word[4  -: G_NB_COLOR];
    end else begin
      pix_r = pix_word[11 -: G_NB_COLOR];
      pix_g = pix_word[7  -: G_NB_COLOR];
      pix_b = pix_word[3  -: G_NB_COLOR];
    end
    if (mode[1])       dout_next = {byte0_reg, {PADW{1'b0}}};
    else if (swap_r_b) dout_next = {pix_b, pix_g, pix_r};
    else               dout_next = {pix_r, pix_g, pix_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_reg     <= 1'b0;
      wrote_any_reg  <= 1'b0;
      byte0_reg      <= '0;
      in_col_reg     <= '0;
      out_col_reg    <= '0;
      in_row_reg     <= '0;
      out_row_reg    <= '0;
      row_base_reg   <= '0;
      addr_reg       <= '0;
      dout_reg       <= '0;
      we_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      line_err_reg   <= 1'b0;
    end else begin
      we_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      line_err_reg   <= 1'b0;
      if (frame_start) begin
        frame_done_reg <= in_frame && wrote_any_reg;
        toggle_reg     <= 1'b0;
        wrote_any_reg  <= 1'b0;
        in_col_reg     <= '0;
        out_col_reg    <= '0;
        in_row_reg     <= '0;
        out_row_reg    <= '0;
        row_base_reg   <= '0;
      end else begin
        if (state_reg == WAIT_LINE && !href_s) begin
          toggle_reg  <= 1'b0;
          in_col_reg  <= '0;
          out_col_reg <= '0;
        end
        if (byte_go) begin
          if (!toggle_reg) begin
            byte0_reg  <= data_s3_reg;
            toggle_reg <= 1'b1;
          end else begin
            toggle_reg <= 1'b0;
            in_col_reg <= in_col_reg + 12'd1;
            if (col_kept && row_kept) begin
              // out_col keeps counting past the image width so line_err sees it.
              if (out_col_reg != 12'hFFF) out_col_reg <= out_col_reg + 12'd1;
              if (in_bounds) begin
                we_reg        <= 1'b1;
                addr_reg      <= G_NB_ADDR'(row_base_reg) + G_NB_ADDR'(out_col_reg);
                dout_reg      <= dout_next;
                wrote_any_reg <= 1'b1;
              end
            end
          end
        end
        if (state_reg == LINE_END) begin
          in_row_reg <= in_row_reg + 12'd1;
          if (row_kept) begin
            row_base_reg <= row_base_reg + COLS_STEP;
            if (out_row_reg != 12'hFFF) out_row_reg <= out_row_reg + 12'd1;
            line_err_reg <= (out_col_reg != COLS_W);
          end
        end
      end
    end
  end

  assign addr       = addr_reg;
  assign dout       = dout_reg;
  assign we         = we_reg;
  assign frame_done = frame_done_reg;
  assign line_err   = line_err_reg;

`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_reg;
  logic [7:0]  err_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      if (frame_done_reg) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (line_err_reg && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign err_cnt   = err_cnt_reg;
`endif

endmodule

// File: tb/tb_cam_capture_scaled.sv
// Testbench for cam_capture_scaled.
// The DUT is built with a 20x15 output image (decimation 2), so a full input
// frame is 40x30 camera pixels and should produce 300 writes.
`timescale 1ns/1ps
module tb_cam_capture_scaled;
  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int NADDR = 9;
  localparam int D     = 2;

  logic        clk = 1'b0, rst_n = 1'b0, pclk = 1'b0, href = 1'b0, vsync = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [1:0]  mode = 2'b00;
  logic        swap_r_b = 1'b0, enable = 1'b0;
  logic [NADDR-1:0] addr;
  logic [11:0] dout;
  logic        we, frame_done, line_err;
`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  cam_capture_scaled #(
    .G_IMG_COLS(COLS), .G_IMG_ROWS(ROWS), .G_NB_ADDR(NADDR),
    .G_NB_COLOR(4), .G_DECIM(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pclk(pclk), .href(href), .vsync(vsync),
    .data(data), .mode(mode), .swap_r_b(swap_r_b), .enable(enable),
    .addr(addr), .dout(dout), .we(we), .frame_done(frame_done), .line_err(line_err)
`ifdef CAM_CAPTURE_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { int a; int d; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int  log_addr[$];
  int  log_dout[$];
  int  obs_fd = 0, obs_le = 0, exp_fd = 0, exp_le = 0;

  // Reference model state
  bit m_active = 1'b0, m_wrote = 1'b0;
  int m_in_row = 0, m_out_row = 0, line_no = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected buffer word from the two camera bytes, by channel arithmetic.
  function automatic int exp_pix(input int b0, input int b1, input logic [1:0] md, input bit sw);
    int r, g, b, t;
    if (md[1]) return b0 * 16;
    if (md == 2'b00) begin
      r = b0 % 16; g = b1 / 16; b = b1 % 16;
    end else begin
      r = (b0 / 8) / 2; g = ((b0 % 8) * 8 + b1 / 32) / 4; b = (b1 % 32) / 2;
    end
    if (sw) begin t = r; r = b; b = t; end
    return r * 256 + g * 16 + b;
  endfunction

  function automatic void model_pixel(input int c, input int b0, input int b1);
    wr_t e;
    if (m_active && (c % D == 0) && (m_in_row % D == 0)) begin
      if ((c / D) < COLS && m_out_row < ROWS) begin
        e.a = m_out_row * COLS + c / D;
        e.d = exp_pix(b0, b1, mode, swap_r_b);
        exp_q.push_back(e);
        m_wrote = 1'b1;
      end
    end
  endfunction

  function automatic void model_line_end(input int npix);
    if (m_active) begin
      if (m_in_row % D == 0) begin
        if ((npix + D - 1) / D != COLS) exp_le++;
        m_out_row++;
      end
      m_in_row++;
    end
  endfunction

  function automatic void model_frame_start();
    if (m_active && m_wrote) exp_fd++;
    m_active  = enable;
    m_wrote   = 1'b0;
    m_in_row  = 0;
    m_out_row = 0;
  endfunction

  // Compare process: every write is checked against the model's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) obs_fd++;
      if (line_err)   obs_le++;
      if (we) begin
        log_addr.push_back(int'(addr));
        log_dout.push_back(int'(dout));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=0x%0h dout=0x%0h, expected no write", addr, dout);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", int'(addr), mon_e.a);
          check("wr_dout", int'(dout), mon_e.d);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int b, input bit glitch);
    data = 8'(b);
    pclk = 1'b0;
    if (glitch) vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    pclk  = 1'b1;
    tick(2);
  endtask

  task automatic send_pixel(input int c, input int b0, input int b1, input bit glitch);
    model_pixel(c, b0, b1);
    send_byte(b0, glitch);
    send_byte(b1, 1'b0);
  endtask

  task automatic end_line(input int npix);
    pclk = 1'b0;
    tick(2);
    href = 1'b0;
    tick(8);
    model_line_end(npix);
    line_no++;
  endtask

  // npix camera pixels; pixel 0 may be overridden; glitch_at < 0 means none.
  task automatic send_line(input int npix, input int glitch_at, input bit use_p0,
                           input int p0b0, input int p0b1);
    int b0, b1;
    href = 1'b1;
    tick(2);
    for (int i = 0; i < npix; i++) begin
      b0 = (line_no * 7 + i * 3 + 1) & 255;
      b1 = (i * 13 + line_no * 5 + 2) & 255;
      if (i == 0 && use_p0) begin b0 = p0b0; b1 = p0b1; end
      send_pixel(i, b0, b1, i == glitch_at);
    end
    end_line(npix);
  endtask

  task automatic send_vsync();
    vsync = 1'b1;
    tick(8);
    vsync = 1'b0;
    tick(8);
    model_frame_start();
    line_no = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, int'(addr), 0);
    check({tag, "_dout"}, int'(dout), 0);
    check({tag, "_we"}, int'(we), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_line_err"}, int'(line_err), 0);
  endtask

  int idx, fd_before, le_before, base_b;

  initial begin
    // Reset state
    tick(3);
    check_outputs_zero("reset");
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(4);

    // Frame A: formats, glitch, short/long lines, rows past the image
    send_vsync();
    idx = log_addr.size();
    send_line(2*COLS, -1, 1'b1, 8'h0A, 8'h5C);
    check("rgb444_addr", log_addr[idx], 0);
    check("rgb444_dout", log_dout[idx], 12'hA5C);
    $display("line A0 rgb444 done, writes=%0d", log_addr.size() - idx);

    send_line(2*COLS, -1, 1'b0, 0, 0);
    swap_r_b = 1'b1;
    idx = log_addr.size();
    send_line(2*COLS, -1, 1'b1, 8'h0A, 8'h5C);
    check("swap_addr", log_addr[idx], 20);
    check("swap_dout", log_dout[idx], 12'hC5A);
    swap_r_b = 1'b0;

    send_line(2*COLS, -1, 1'b0, 0, 0);
    mode = 2'b01;
    idx = log_addr.size();
    send_line(2*COLS, -1, 1'b1, 8'hF8, 8'h1F);
    check("rgb565_addr", log_addr[idx], 40);
    check("rgb565_dout", log_dout[idx], 12'hF0F);

    send_line(2*COLS, -1, 1'b0, 0, 0);
    mode = 2'b10;
    idx = log_addr.size();
    send_line(2*COLS, -1, 1'b1, 8'hB7, 8'h00);
    check("gray_addr", log_addr[idx], 60);
    check("gray_dout", log_dout[idx], 12'hB70);
    mode = 2'b00;

    send_line(2*COLS, -1, 1'b0, 0, 0);
    fd_before = obs_fd;
    send_line(2*COLS, 5, 1'b0, 0, 0);          // line 8 with a 2-clk vsync glitch
    check("glitch_no_frame_done", obs_fd, fd_before);
    $display("line A8 glitch done, frame_done=%0d", obs_fd);

    send_line(2*COLS, -1, 1'b0, 0, 0);
    le_before = obs_le;
    send_line(2*COLS - 4, -1, 1'b0, 0, 0);     // line 10: 18 kept pixels
    check("short_line_err", obs_le, le_before + 1);
    send_line(2*COLS, -1, 1'b0, 0, 0);
    idx = log_addr.size();
    send_line(2*COLS, -1, 1'b0, 0, 0);         // line 12
    check("after_short_addr", log_addr[idx], 120);
    send_line(2*COLS, -1, 1'b0, 0, 0);
    send_line(2*COLS + 4, -1, 1'b0, 0, 0);     // line 14: 22 kept pixels
    for (int l = 15; l < 32; l++) send_line(2*COLS, -1, 1'b0, 0, 0);
    check("frameA_drain", exp_q.size(), 0);
    check("frameA_line_err", obs_le, 2);
    $display("frame A done, writes=%0d line_err=%0d", log_addr.size(), obs_le);

    // Frame B: clean 40x30 frame with decimation
    send_vsync();
    check("frameA_done", obs_fd, 1);
    base_b = log_addr.size();
    for (int l = 0; l < 30; l++) send_line(2*COLS, -1, 1'b0, 0, 0);
    send_vsync();
    check("decim_writes", log_addr.size() - base_b, 300);
    check("decim_last_addr", log_addr[log_addr.size() - 1], 299);
    check("frameB_done", obs_fd, 2);
    $display("frame B done, writes=%0d", log_addr.size() - base_b);

    // Frame C: reset mid-line
    href = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) send_pixel(i, 8'h33 + i, 8'h44 + i, 1'b0);
    tick(8);
    idx = log_addr.size();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    m_active  = 1'b0;
    m_wrote   = 1'b0;
    m_in_row  = 0;
    m_out_row = 0;
    check("midreset_drain", exp_q.size(), 0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 10; i < 2*COLS; i++) send_pixel(i, 8'h55, 8'h66, 1'b0);
    end_line(2*COLS);
    send_line(2*COLS, -1, 1'b0, 0, 0);
    send_line(2*COLS, -1, 1'b0, 0, 0);
    check("post_reset_no_we", log_addr.size(), idx);
    send_vsync();
    check("post_reset_no_fd", obs_fd, 2);
    idx = log_addr.size();
    send_line(2*COLS, -1, 1'b0, 0, 0);
    send_line(2*COLS, -1, 1'b0, 0, 0);
    check("resume_writes", log_addr.size() - idx, 20);
    check("resume_first_addr", log_addr[idx], 0);
    send_vsync();
    $display("frame C done, writes after resume=%0d", log_addr.size() - idx);

    check("total_frame_done", obs_fd, exp_fd);
    check("total_frame_done_lit", obs_fd, 3);
    check("total_line_err", obs_le, exp_le);
    check("final_drain", exp_q.size(), 0);
`ifdef CAM_CAPTURE_STATS_EN
    check("stats_frame_cnt", int'(frame_cnt), 1);
    check("stats_err_cnt", int'(err_cnt), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
